// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one Avalon RAM port between two camera pixel writers
// and the HDMI display reader (single-beat requests, display-read priority).
//
// Ports (all on rising clk_25_2m; reset is synchronous, active-low):
//   ram_rdy                     : RAM calibrated; nothing issues while low
//   cam1/cam2/disp _req,_addr   : requests, held until the matching grant
//   cam1/cam2 _wdata            : camera write data
//   cam1/cam2/disp _gnt         : one-cycle pulse after the RAM accepts
//   disp_rdata/disp_rvalid      : registered read return to the display
//   avl_*                       : Avalon master side toward RAM port 0
//   busy                        : request in flight or reads outstanding
//   stat_cam1/stat_cam2/stat_disp : grant counters
//
// Build option: define ARB_STATS_EN to build the saturating 32-bit grant
// counters; without it the stat_* outputs are tied to zero.

module mem_port_arb #(
    parameter int ADDR_W          = 29,
    parameter int DATA_W          = 32,
    parameter int MAX_RD_RUN      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_25_2m,
    input  logic              reset,
    input  logic              ram_rdy,
    input  logic              cam1_req,
    input  logic              cam2_req,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] cam1_addr,
    input  logic [ADDR_W-1:0] cam2_addr,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic [DATA_W-1:0] cam1_wdata,
    input  logic [DATA_W-1:0] cam2_wdata,
    output logic              cam1_gnt,
    output logic              cam2_gnt,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              avl_ready,
    output logic              avl_write_req,
    output logic              avl_read_req,
    output logic [ADDR_W-1:0] avl_addr,
    output logic [DATA_W-1:0] avl_wdata,
    input  logic [DATA_W-1:0] avl_rdata,
    input  logic              avl_rdata_valid,
    output logic              busy,
    output logic [31:0]       stat_cam1,
    output logic [31:0]       stat_cam2,
    output logic [31:0]       stat_disp
);

    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    typedef enum logic [1:0] {
        WHO_CAM1,
        WHO_CAM2,
        WHO_DISP
    } who_t;

    state_t             r_state;
    state_t             w_nxt_state;
    who_t               r_who;
    who_t               w_sel;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_is_rd;
    logic               r_rr_cam2;
    logic [RUN_W-1:0]   r_rd_run;
    logic [OUT_W-1:0]   r_outst;
    logic               r_cam1_gnt;
    logic               r_cam2_gnt;
    logic               r_disp_gnt;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_take;
    logic               w_accept;
    logic               w_cam_any;
    logic               w_disp_ok;
    logic               w_rd_inc;
    logic               w_rd_dec;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    assign w_cam_any = cam1_req | cam2_req;

    // Display loses priority only once it has run MAX_RD_RUN reads in a
    // row while a camera waits, or when the read pipeline is full.
    assign w_disp_ok = disp_req
                    && (r_outst < OUT_W'(MAX_OUTSTANDING))
                    && !((r_rd_run == RUN_W'(MAX_RD_RUN)) && w_cam_any);

    always_comb begin
        w_nxt_state = r_state;
        w_take      = 1'b0;
        w_accept    = 1'b0;
        w_sel       = WHO_CAM1;
        unique case (r_state)
            IDLE: begin
                if (ram_rdy) begin
                    if (w_disp_ok) begin
                        w_sel  = WHO_DISP;
                        w_take = 1'b1;
                    end else if (cam1_req && cam2_req) begin
                        w_sel  = r_rr_cam2 ? WHO_CAM2 : WHO_CAM1;
                        w_take = 1'b1;
                    end else if (cam1_req) begin
                        w_sel  = WHO_CAM1;
                        w_take = 1'b1;
                    end else if (cam2_req) begin
                        w_sel  = WHO_CAM2;
                        w_take = 1'b1;
                    end
                end
                if (w_take) begin
                    w_nxt_state = ISSUE;
                end
            end
            ISSUE: begin
                if (avl_ready) begin
                    w_accept    = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_sel_addr  = cam1_addr;
        w_sel_wdata = cam1_wdata;
        unique case (w_sel)
            WHO_CAM2: begin
                w_sel_addr  = cam2_addr;
                w_sel_wdata = cam2_wdata;
            end
            WHO_DISP: begin
                w_sel_addr  = disp_addr;
                w_sel_wdata = '0;
            end
            default: begin
                w_sel_addr  = cam1_addr;
                w_sel_wdata = cam1_wdata;
            end
        endcase
    end

    assign w_rd_inc = w_accept && r_is_rd;
    // A return with nothing outstanding is stray (e.g. a read issued
    // before a reset) and is dropped entirely.
    assign w_rd_dec = avl_rdata_valid && (r_outst != '0);

    always_ff @(posedge clk_25_2m) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_who      <= WHO_CAM1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_rd    <= 1'b0;
            r_rr_cam2  <= 1'b0;
            r_rd_run   <= '0;
            r_outst    <= '0;
            r_cam1_gnt <= 1'b0;
            r_cam2_gnt <= 1'b0;
            r_disp_gnt <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_cam1_gnt <= w_accept && (r_who == WHO_CAM1);
            r_cam2_gnt <= w_accept && (r_who == WHO_CAM2);
            r_disp_gnt <= w_accept && (r_who == WHO_DISP);

            if (w_take) begin
                r_who   <= w_sel;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_is_rd <= (w_sel == WHO_DISP);
            end

            if (w_accept && (r_who != WHO_DISP)) begin
                r_rr_cam2 <= (r_who == WHO_CAM1);
            end

            if (w_accept) begin
                if (r_who == WHO_DISP) begin
                    if (r_rd_run != RUN_W'(MAX_RD_RUN)) begin
                        r_rd_run <= r_rd_run + 1'b1;
                    end
                end else begin
                    r_rd_run <= '0;
                end
            end else if ((r_state == IDLE) && !w_cam_any) begin
                r_rd_run <= '0;
            end

            if (w_rd_inc && !w_rd_dec) begin
                r_outst <= r_outst + 1'b1;
            end else if (!w_rd_inc && w_rd_dec) begin
                r_outst <= r_outst - 1'b1;
            end

            r_rvalid <= w_rd_dec;
            if (w_rd_dec) begin
                r_rdata <= avl_rdata;
            end
        end
    end

    assign cam1_gnt      = r_cam1_gnt;
    assign cam2_gnt      = r_cam2_gnt;
    assign disp_gnt      = r_disp_gnt;
    assign disp_rvalid   = r_rvalid;
    assign disp_rdata    = r_rdata;
    assign avl_write_req = (r_state == ISSUE) && !r_is_rd;
    assign avl_read_req  = (r_state == ISSUE) && r_is_rd;
    assign avl_addr      = r_addr;
    assign avl_wdata     = r_wdata;
    assign busy          = (r_state == ISSUE) || (r_outst != '0);

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_cam1;
    logic [31:0] r_stat_cam2;
    logic [31:0] r_stat_disp;

    always_ff @(posedge clk_25_2m) begin
        if (!reset) begin
            r_stat_cam1 <= '0;
            r_stat_cam2 <= '0;
            r_stat_disp <= '0;
        end else if (w_accept) begin
            if ((r_who == WHO_CAM1) && (r_stat_cam1 != '1)) begin
                r_stat_cam1 <= r_stat_cam1 + 1'b1;
            end
            if ((r_who == WHO_CAM2) && (r_stat_cam2 != '1)) begin
                r_stat_cam2 <= r_stat_cam2 + 1'b1;
            end
            if ((r_who == WHO_DISP) && (r_stat_disp != '1)) begin
                r_stat_disp <= r_stat_disp + 1'b1;
            end
        end
    end

    assign stat_cam1 = r_stat_cam1;
    assign stat_cam2 = r_stat_cam2;
    assign stat_disp = r_stat_disp;
`else
    assign stat_cam1 = 32'h0;
    assign stat_cam2 = 32'h0;
    assign stat_disp = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed scenarios plus random traffic for mem_port_arb,
// checked every cycle against a transaction-level model of the arbiter.

module tb_mem_port_arb;

    localparam int AW     = 29;
    localparam int DW     = 32;
    localparam int MAXRUN = 8;
    localparam int MAXO   = 4;

    logic          clk_25_2m = 1'b0;
    logic          reset     = 1'b0;
    logic          ram_rdy   = 1'b0;
    logic          b_req  [3];
    logic [AW-1:0] b_addr [3];
    logic [DW-1:0] b_wd   [3];
    logic          avl_ready       = 1'b0;
    logic [DW-1:0] avl_rdata       = '0;
    logic          avl_rdata_valid = 1'b0;

    logic          cam1_gnt, cam2_gnt, disp_gnt;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          avl_write_req, avl_read_req;
    logic [AW-1:0] avl_addr;
    logic [DW-1:0] avl_wdata;
    logic          busy;
    logic [31:0]   stat_cam1, stat_cam2, stat_disp;

    always #5 clk_25_2m = ~clk_25_2m;

    mem_port_arb dut (
        .clk_25_2m       (clk_25_2m),
        .reset           (reset),
        .ram_rdy         (ram_rdy),
        .cam1_req        (b_req[0]),
        .cam2_req        (b_req[1]),
        .disp_req        (b_req[2]),
        .cam1_addr       (b_addr[0]),
        .cam2_addr       (b_addr[1]),
        .disp_addr       (b_addr[2]),
        .cam1_wdata      (b_wd[0]),
        .cam2_wdata      (b_wd[1]),
        .cam1_gnt        (cam1_gnt),
        .cam2_gnt        (cam2_gnt),
        .disp_gnt        (disp_gnt),
        .disp_rdata      (disp_rdata),
        .disp_rvalid     (disp_rvalid),
        .avl_ready       (avl_ready),
        .avl_write_req   (avl_write_req),
        .avl_read_req    (avl_read_req),
        .avl_addr        (avl_addr),
        .avl_wdata       (avl_wdata),
        .avl_rdata       (avl_rdata),
        .avl_rdata_valid (avl_rdata_valid),
        .busy            (busy),
        .stat_cam1       (stat_cam1),
        .stat_cam2       (stat_cam2),
        .stat_disp       (stat_disp)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s t=%0t actual=%0h required=%0h",
                     nm, $time, act, exp);
        else
            n_pass++;
    endtask

    // Model: one pending transaction, a count of reads in flight.
    bit            m_pend;
    int            m_who;
    bit            m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    int            m_rr;
    int            m_run;
    int            m_out;
    bit            m_acc_rd;
    bit            e_gnt [3];
    bit            e_rvalid;
    logic [DW-1:0] e_rdata;
    longint        stat [3];

    task automatic model_step();
        bit rv;
        bit cam_any;
        int pick;
        e_gnt    = '{0, 0, 0};
        m_acc_rd = 0;
        if (!reset) begin
            m_pend   = 0;
            m_rd     = 0;
            m_addr   = '0;
            m_wd     = '0;
            m_rr     = 0;
            m_run    = 0;
            m_out    = 0;
            e_rvalid = 0;
            e_rdata  = '0;
            for (int i = 0; i < 3; i++) stat[i] = 0;
            return;
        end
        rv       = avl_rdata_valid && (m_out > 0);
        e_rvalid = rv;
        if (rv) e_rdata = avl_rdata;
        if (m_pend) begin
            if (avl_ready) begin
                e_gnt[m_who] = 1;
                if (stat[m_who] < 64'hFFFF_FFFF) stat[m_who]++;
                if (m_who == 2) begin
                    m_run    = (m_run < MAXRUN) ? m_run + 1 : MAXRUN;
                    m_acc_rd = 1;
                end else begin
                    m_run = 0;
                    m_rr  = 1 - m_who;
                end
                m_pend = 0;
            end
        end else begin
            cam_any = b_req[0] || b_req[1];
            pick    = -1;
            if (ram_rdy) begin
                if (b_req[2] && m_out < MAXO &&
                    !(m_run == MAXRUN && cam_any)) pick = 2;
                else if (b_req[0] && b_req[1]) pick = m_rr;
                else if (b_req[0]) pick = 0;
                else if (b_req[1]) pick = 1;
            end
            if (!cam_any) m_run = 0;
            if (pick >= 0) begin
                m_pend = 1;
                m_who  = pick;
                m_rd   = (pick == 2);
                m_addr = b_addr[pick];
                m_wd   = b_wd[pick];
            end
        end
        if (m_acc_rd) m_out++;
        if (rv) m_out--;
    endtask

    task automatic check();
        chk("wr_req", 64'(avl_write_req), 64'(m_pend && !m_rd));
        chk("rd_req", 64'(avl_read_req), 64'(m_pend && m_rd));
        if (m_pend) chk("addr", 64'(avl_addr), 64'(m_addr));
        if (m_pend && !m_rd) chk("wdata", 64'(avl_wdata), 64'(m_wd));
        chk("gnt1", 64'(cam1_gnt), 64'(e_gnt[0]));
        chk("gnt2", 64'(cam2_gnt), 64'(e_gnt[1]));
        chk("gntd", 64'(disp_gnt), 64'(e_gnt[2]));
        chk("rvalid", 64'(disp_rvalid), 64'(e_rvalid));
        if (e_rvalid) chk("rdata", 64'(disp_rdata), 64'(e_rdata));
        chk("busy", 64'(busy), 64'(m_pend || m_out > 0));
`ifdef ARB_STATS_EN
        chk("stat1", 64'(stat_cam1), 64'(stat[0]));
        chk("stat2", 64'(stat_cam2), 64'(stat[1]));
        chk("statd", 64'(stat_disp), 64'(stat[2]));
`else
        chk("stat0", 64'(stat_cam1 | stat_cam2 | stat_disp), 64'd0);
`endif
    endtask

    // Stimulus environment.
    bit en [3];
    bit rand_req = 0;
    bit rnd_env  = 0;
    bit auto_ret = 1;
    bit rnd_dly  = 0;
    bit drain_v  = 0;
    bit man_v    = 0;
    bit spur     = 0;
    int ret_dly  = 2;
    int edge_n   = 0;
    int ret [$];
    int glog [$];

    task automatic new_req(input int i);
        b_req[i]  = 1'b1;
        b_addr[i] = AW'($urandom);
        b_wd[i]   = $urandom;
    endtask

    task automatic tick();
        bit v;
        int t;
        v = 0;
        if (drain_v) v = (m_out > 0);
        else if (ret.size() > 0 && ret[0] == edge_n + 1) begin
            v = 1;
            void'(ret.pop_front());
        end
        if (man_v) begin
            v     = 1;
            man_v = 0;
        end
        if (spur && $urandom_range(39) == 0) v = 1;
        avl_rdata_valid = v;
        avl_rdata       = $urandom;
        if (rnd_env) begin
            avl_ready = ($urandom_range(9) < 7);
            ram_rdy   = ($urandom_range(19) != 0);
        end
        @(posedge clk_25_2m);
        model_step();
        edge_n++;
        if (m_acc_rd && auto_ret && !drain_v) begin
            t = edge_n + (rnd_dly ? $urandom_range(4, 1) : ret_dly);
            if (ret.size() > 0 && t <= ret[$]) t = ret[$] + 1;
            ret.push_back(t);
        end
        @(negedge clk_25_2m);
        check();
        for (int i = 0; i < 3; i++) begin
            if (e_gnt[i]) begin
                glog.push_back(i);
                if (en[i]) new_req(i);
                else b_req[i] = 1'b0;
            end
        end
        if (rand_req)
            for (int i = 0; i < 3; i++)
                if (!b_req[i] && $urandom_range(3) == 0) new_req(i);
    endtask

    task automatic drain();
        en       = '{0, 0, 0};
        rand_req = 0;
        rnd_env  = 0;
        spur     = 0;
        drain_v  = 1;
        avl_ready = 1'b1;
        ram_rdy   = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (!b_req[0] && !b_req[1] && !b_req[2] && !m_pend && m_out == 0)
                break;
            tick();
        end
        chk("drain_idle", 64'(busy), 64'd0);
        drain_v = 0;
        ret.delete();
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 3; i++) begin
            b_req[i]  = 1'b0;
            b_addr[i] = '0;
            b_wd[i]   = '0;
            en[i]     = 0;
        end

        // Reset state.
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_req", 64'(avl_write_req | avl_read_req), 64'd0);
        chk("rst_gnt", 64'(cam1_gnt | cam2_gnt | disp_gnt), 64'd0);
        chk("rst_addr", 64'(avl_addr), 64'd0);
        chk("rst_wdata", 64'(avl_wdata), 64'd0);
        chk("rst_rdata", 64'(disp_rdata), 64'd0);
        reset = 1'b1;

        // RAM not ready: nothing may issue.
        en = '{1, 1, 1};
        for (int i = 0; i < 3; i++) new_req(i);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (avl_write_req || avl_read_req || cam1_gnt || cam2_gnt ||
                disp_gnt) cnt++;
        end
        chk("rdy0_quiet", 64'(cnt), 64'd0);
        ram_rdy   = 1'b1;
        avl_ready = 1'b0;
        tick();
        chk("rdy_rd", 64'(avl_read_req), 64'd1);
        chk("rdy_addr", 64'(avl_addr), 64'(b_addr[2]));
        drain();

        // Cameras only: strict alternation starting at cam1.
        glog.delete();
        en = '{1, 1, 0};
        new_req(0);
        new_req(1);
        for (int k = 0; k < 100 && glog.size() < 8; k++) tick();
        chk("B_count", 64'(glog.size() >= 8), 64'd1);
        if (glog.size() >= 8)
            for (int k = 0; k < 8; k++)
                chk("B_order", 64'(glog[k]), 64'(k % 2));
        drain();

        // All three held: 8 display reads per camera grant.
        glog.delete();
        auto_ret = 1;
        ret_dly  = 2;
        en = '{1, 1, 1};
        for (int i = 0; i < 3; i++) new_req(i);
        for (int k = 0; k < 200 && glog.size() < 18; k++) tick();
        chk("C_count", 64'(glog.size() >= 18), 64'd1);
        if (glog.size() >= 18) begin
            for (int k = 0; k < 18; k++)
                chk("C_class", 64'(glog[k] == 2), 64'(!(k == 8 || k == 17)));
            chk("C_rr", 64'(glog[17]), 64'(glog[8] == 0 ? 1 : 0));
        end
        drain();

        // Display only, no returns: outstanding limit.
        auto_ret = 0;
        en = '{0, 0, 1};
        new_req(2);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (avl_read_req) cnt++;
        end
        chk("D_four", 64'(cnt), 64'd4);
        chk("D_stall", 64'(avl_read_req), 64'd0);
        man_v = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (avl_read_req) cnt++;
        end
        chk("D_five", 64'(cnt), 64'd5);
        drain();
        auto_ret = 1;

        // Stalled write: request held stable until avl_ready.
        en        = '{0, 0, 0};
        avl_ready = 1'b0;
        b_addr[0] = 29'h1F;
        b_wd[0]   = $urandom;
        b_req[0]  = 1'b1;
        tick();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (avl_write_req && avl_addr == 29'h1F && !cam1_gnt) cnt++;
        end
        chk("E_stable", 64'(cnt), 64'd10);
        avl_ready = 1'b1;
        tick();
        chk("E_gnt", 64'(cam1_gnt), 64'd1);
        drain();

        // Reset during ISSUE with two reads outstanding.
        auto_ret = 0;
        en = '{0, 0, 1};
        new_req(2);
        for (int k = 0; k < 20 && m_out < 2; k++) tick();
        chk("F_out2", 64'(m_out), 64'd2);
        avl_ready = 1'b0;
        tick();
        chk("F_issue", 64'(avl_read_req), 64'd1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) b_req[i] = 1'b0;
        tick();
        chk("F_rd", 64'(avl_read_req | avl_write_req), 64'd0);
        chk("F_gnt", 64'(cam1_gnt | cam2_gnt | disp_gnt), 64'd0);
        chk("F_busy", 64'(busy), 64'd0);
        chk("F_addr", 64'(avl_addr), 64'd0);
        chk("F_stat", 64'(stat_cam1 | stat_cam2 | stat_disp), 64'd0);
        reset     = 1'b1;
        avl_ready = 1'b1;
        man_v     = 1;
        cnt = 0;
        repeat (2) begin
            tick();
            if (disp_rvalid) cnt++;
        end
        chk("F_norv", 64'(cnt), 64'd0);

        // Random traffic.
        auto_ret = 1;
        rnd_dly  = 1;
        rand_req = 1;
        rnd_env  = 1;
        spur     = 1;
        repeat (800) tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates one Avalon port of the 4-port LPDDR2 RAM interface between three single-beat requesters.
- Requesters: camera 1 pixel writer, camera 2 pixel writer, HDMI display reader.
- Display reads have priority, bounded by a starvation guard. Camera writes alternate round-robin.
- Sits between the per-camera capture/frame-buffer address logic and the RAM interface port 0, in the clk_25_2m domain.

Parameters:
- ADDR_W, 29, Avalon word address width.
- DATA_W, 32, Avalon data width.
- MAX_RD_RUN, 8, maximum consecutive display reads granted while any camera request is pending.
- MAX_OUTSTANDING, 4, maximum issued reads awaiting rd_data_valid.

Ports:
- clk_25_2m  input  1  system pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-low.
- ram_rdy  input  1  memory calibration/init complete; no issue while low.
- cam1_req / cam2_req / disp_req  input  1 each  request, held until matching grant.
- cam1_addr / cam2_addr / disp_addr  input  ADDR_W each  request address.
- cam1_wdata / cam2_wdata  input  DATA_W each  write data.
- cam1_gnt / cam2_gnt / disp_gnt  output  1 each  one-cycle pulse: transaction accepted by RAM.
- disp_rdata  output  DATA_W  read data to display.
- disp_rvalid  output  1  disp_rdata valid, one cycle.
- avl_ready  input  1  RAM port ready (accepts request this edge).
- avl_write_req / avl_read_req  output  1 each  Avalon request strobes.
- avl_addr  output  ADDR_W  Avalon address.
- avl_wdata  output  DATA_W  Avalon write data.
- avl_rdata  input  DATA_W  Avalon read data.
- avl_rdata_valid  input  1  read data valid.
- busy  output  1  high in ISSUE state or while outstanding reads are nonzero.
- stat_cam1 / stat_cam2 / stat_disp  output  32 each  grant counters (see Optional Feature).

Behaviour:
- Reset (reset==0 at edge): state=IDLE; all gnt, avl_*_req, disp_rvalid=0; avl_addr, avl_wdata, disp_rdata=0; rr_ptr=cam1; rd_run=0; outstanding=0.
- Reset asserted mid-transaction aborts it: no grant is issued. Reads already in flight are discarded (rvalid suppressed while reset==0). The counter restarts at 0.
- IDLE: if ram_rdy==0, stay. Otherwise select a winner, register addr/wdata/request type, go to ISSUE. With no request, stay.
- Winner selection:
  - disp wins if disp_req && outstanding<MAX_OUTSTANDING && !(rd_run==MAX_RD_RUN && (cam1_req||cam2_req)).
  - Otherwise, cameras use round-robin from rr_ptr.
  - A single camera request wins regardless of rr_ptr.
- ISSUE: assert exactly one of avl_write_req/avl_read_req with registered addr/data, held stable until an edge with avl_ready==1. On that edge:
  - deassert the request;
  - pulse the winner's gnt for one cycle;
  - return to IDLE.
- Throughput: maximum one transaction per 2 cycles. Latency from req (in IDLE) to avl request is 1 cycle; gnt pulse is the cycle after the accepting edge.
- rr_ptr toggles to the other camera after each camera grant. It is unchanged by display grants.
- rd_run:
  - increments on each disp grant, saturating at MAX_RD_RUN;
  - clears on any camera grant;
  - clears on any IDLE cycle with no camera request.
- outstanding:
  - +1 on read accept, -1 on avl_rdata_valid;
  - simultaneous accept and valid leaves it unchanged;
  - never exceeds MAX_OUTSTANDING;
  - valid with outstanding==0 is ignored (no underflow).
- disp_rdata/disp_rvalid: avl_rdata registered, 1-cycle latency. Valid pulses are forwarded even while in ISSUE.
- Requester dropping req before grant: the transaction already in ISSUE still completes and is granted. Requesters must not do this.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: stat_cam1/stat_cam2/stat_disp count grants per requester. They are 32-bit, saturate at 32'hFFFFFFFF, and clear on reset.
- Undefined: counters are not built, and stat_* outputs are tied to 32'h0.

Test Plan:
- ram_rdy=0, all req=1 for 50 cycles -> no avl_*_req, no gnt. Raise ram_rdy -> avl_read_req at addr disp_addr 1 cycle later.
- Only cam1_req and cam2_req held, avl_ready=1, 8 grants -> gnt order cam1,cam2,cam1,cam2,...; avl_wdata matches each camera's wdata.
- disp_req, cam1_req, cam2_req all held, avl_ready=1, avl_rdata_valid returned 2 cycles after each read accept -> 8 disp grants, 1 camera grant, 8 disp grants, 1 camera grant, ...; no camera starves.
- disp_req only, avl_rdata_valid never asserted -> exactly 4 reads accepted, then no further avl_read_req. Assert one valid -> one more read issues.
- avl_ready held 0 for 10 cycles during ISSUE (write, addr 29'h1F) -> avl_write_req and avl_addr stay stable 10 cycles; gnt only after avl_ready=1.
- Reset low during ISSUE with 2 reads outstanding -> next cycle all outputs 0. Subsequent avl_rdata_valid produces no disp_rvalid. With ARB_STATS_EN, stats read 0.
